// File: rtl/hazard_sequencer_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM encodings, syscall exit code
// and the register-match helper used by the load-use compare.
package hazard_sequencer_pkg;

    localparam int unsigned RegAddrW      = 5;
    localparam int unsigned HS_STATE_BIT  = 2;

    localparam logic [HS_STATE_BIT-1:0] HS_RUN   = 2'd0;
    localparam logic [HS_STATE_BIT-1:0] HS_DRAIN = 2'd1;
    localparam logic [HS_STATE_BIT-1:0] HS_FIRE  = 2'd2;
    localparam logic [HS_STATE_BIT-1:0] HS_HALT  = 2'd3;

    // $v0 service code that ends the program.
    localparam int unsigned SYSCALL_EXIT_CODE = 10;

    typedef enum logic [HS_STATE_BIT-1:0] {
        StRun   = HS_RUN,
        StDrain = HS_DRAIN,
        StFire  = HS_FIRE,
        StHalt  = HS_HALT
    } hs_state_e;

    function automatic logic reg_hit(input logic                en,
                                     input logic [RegAddrW-1:0] src,
                                     input logic [RegAddrW-1:0] dst);
        return en && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_sequencer_sat_counter.sv
// Saturating up-counter: increments on inc_i, sticks at all-ones, cleared by async reset.
module hazard_sequencer_sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline sequencer: load-use stalls, redirect flushes, syscall drain/fire/halt and
// saturating stall/flush performance counters.
module hazard_sequencer
    import hazard_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid_i,
    input  logic [RegAddrW-1:0] id_rs_i,
    input  logic [RegAddrW-1:0] id_rt_i,
    input  logic                id_use_rs_i,
    input  logic                id_use_rt_i,
    input  logic                id_syscall_i,
    input  logic                ex_valid_i,
    input  logic                ex_mem_read_i,
    input  logic [RegAddrW-1:0] ex_dst_i,
    input  logic                ex_redirect_i,
    input  logic                mem_valid_i,
    input  logic                wb_valid_i,
    input  logic                syscall_halt_i,
    output logic                stall_if_o,
    output logic                stall_id_o,
    output logic                bubble_ex_o,
    output logic                flush_id_o,
    output logic                syscall_fire_o,
    output logic                halted_o,
    output logic [CNT_W-1:0]    stall_cnt_o,
    output logic [CNT_W-1:0]    flush_cnt_o
);

    hs_state_e state_q, state_d;
    logic      halted_q;
    logic      load_use;
    logic      stall, bubble, flush, fire;

    assign load_use = id_valid_i && ex_valid_i && ex_mem_read_i && (ex_dst_i != '0) &&
                      (reg_hit(id_use_rs_i, id_rs_i, ex_dst_i) ||
                       reg_hit(id_use_rt_i, id_rt_i, ex_dst_i));

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        bubble  = 1'b0;
        flush   = 1'b0;
        fire    = 1'b0;
        unique case (state_q)
            StRun: begin
                if (ex_redirect_i) begin
                    flush = 1'b1;
                end else if (load_use) begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                end else if (id_valid_i && id_syscall_i) begin
                    stall   = 1'b1;
                    bubble  = 1'b1;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                stall  = 1'b1;
                bubble = 1'b1;
                if (!(ex_valid_i || mem_valid_i || wb_valid_i)) begin
                    state_d = StFire;
                end
            end
            StFire: begin
                stall = 1'b1;
                fire  = 1'b1;
                if (syscall_halt_i) begin
                    state_d = StHalt;
                end else begin
                    // Kill the syscall sitting in IF/ID so it retires instead of re-firing.
                    flush   = 1'b1;
                    state_d = StRun;
                end
            end
            StHalt: begin
                stall  = 1'b1;
                bubble = 1'b1;
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StRun;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d == StHalt);
        end
    end

    // Controls are forced low while reset is asserted, independent of the inputs.
    assign stall_if_o     = rst_n & stall;
    assign stall_id_o     = rst_n & stall;
    assign bubble_ex_o    = rst_n & bubble;
    assign flush_id_o     = rst_n & flush;
    assign syscall_fire_o = rst_n & fire;
    assign halted_o       = halted_q;

    hazard_sequencer_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (stall_id_o),
        .cnt_o (stall_cnt_o)
    );

    hazard_sequencer_sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (flush_id_o),
        .cnt_o (flush_cnt_o)
    );

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: vector table for single-cycle hazards plus
// hand-written syscall, halt, saturation and mid-drain reset sequences.
module tb_hazard_sequencer;

    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic bubble_ex;
        logic flush_id;
        logic fire;
        logic halted;
    } ctl_t;

    typedef struct {
        string      name;
        logic       id_valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic       syscall;
        logic       ex_valid;
        logic       mem_read;
        logic [4:0] dst;
        logic       redirect;
        ctl_t       exp;
    } vec_t;

    typedef struct {
        string       name;
        ctl_t        ctl;
        logic [31:0] stall_cnt;
        logic [31:0] flush_cnt;
        logic [3:0]  stall4;
        logic [3:0]  flush4;
    } sb_t;

    localparam ctl_t CtlNone     = 6'b000000;
    localparam ctl_t CtlStall    = 6'b111000;
    localparam ctl_t CtlFlush    = 6'b000100;
    localparam ctl_t CtlFireRun  = 6'b110110;
    localparam ctl_t CtlFireHalt = 6'b110010;
    localparam ctl_t CtlHalt     = 6'b111001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_use_rs, id_use_rt, id_syscall;
    logic [4:0]  id_rs, id_rt, ex_dst;
    logic        ex_valid, ex_mem_read, ex_redirect, mem_valid, wb_valid, syscall_halt;
    logic        stall_if, stall_id, bubble_ex, flush_id, syscall_fire, halted;
    logic [31:0] stall_cnt, flush_cnt;
    logic        stall_if4, stall_id4, bubble_ex4, flush_id4, syscall_fire4, halted4;
    logic [3:0]  stall_cnt4, flush_cnt4;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] t_stall, t_flush;
    logic [3:0]  t_stall4, t_flush4;
    sb_t         sbq[$];
    vec_t        vecs[$];

    always #5 clk = ~clk;

    hazard_sequencer #(.CNT_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid_i     (id_valid),
        .id_rs_i        (id_rs),
        .id_rt_i        (id_rt),
        .id_use_rs_i    (id_use_rs),
        .id_use_rt_i    (id_use_rt),
        .id_syscall_i   (id_syscall),
        .ex_valid_i     (ex_valid),
        .ex_mem_read_i  (ex_mem_read),
        .ex_dst_i       (ex_dst),
        .ex_redirect_i  (ex_redirect),
        .mem_valid_i    (mem_valid),
        .wb_valid_i     (wb_valid),
        .syscall_halt_i (syscall_halt),
        .stall_if_o     (stall_if),
        .stall_id_o     (stall_id),
        .bubble_ex_o    (bubble_ex),
        .flush_id_o     (flush_id),
        .syscall_fire_o (syscall_fire),
        .halted_o       (halted),
        .stall_cnt_o    (stall_cnt),
        .flush_cnt_o    (flush_cnt)
    );

    hazard_sequencer #(.CNT_W(4)) dut4 (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid_i     (id_valid),
        .id_rs_i        (id_rs),
        .id_rt_i        (id_rt),
        .id_use_rs_i    (id_use_rs),
        .id_use_rt_i    (id_use_rt),
        .id_syscall_i   (id_syscall),
        .ex_valid_i     (ex_valid),
        .ex_mem_read_i  (ex_mem_read),
        .ex_dst_i       (ex_dst),
        .ex_redirect_i  (ex_redirect),
        .mem_valid_i    (mem_valid),
        .wb_valid_i     (wb_valid),
        .syscall_halt_i (syscall_halt),
        .stall_if_o     (stall_if4),
        .stall_id_o     (stall_id4),
        .bubble_ex_o    (bubble_ex4),
        .flush_id_o     (flush_id4),
        .syscall_fire_o (syscall_fire4),
        .halted_o       (halted4),
        .stall_cnt_o    (stall_cnt4),
        .flush_cnt_o    (flush_cnt4)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mkv(input string nm, input logic idv, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic urs, input logic urt,
                                 input logic sc, input logic exv, input logic mr,
                                 input logic [4:0] dst, input logic rd, input ctl_t e);
        vec_t v;
        v.name = nm; v.id_valid = idv; v.rs = rs; v.rt = rt; v.use_rs = urs; v.use_rt = urt;
        v.syscall = sc; v.ex_valid = exv; v.mem_read = mr; v.dst = dst; v.redirect = rd;
        v.exp = e;
        return v;
    endfunction

    task automatic idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; id_syscall = 0;
        ex_valid = 0; ex_mem_read = 0; ex_dst = 0; ex_redirect = 0;
        mem_valid = 0; wb_valid = 0; syscall_halt = 0;
    endtask

    task automatic apply(input vec_t v);
        idle();
        id_valid = v.id_valid; id_rs = v.rs; id_rt = v.rt; id_use_rs = v.use_rs;
        id_use_rt = v.use_rt; id_syscall = v.syscall; ex_valid = v.ex_valid;
        ex_mem_read = v.mem_read; ex_dst = v.dst; ex_redirect = v.redirect;
    endtask

    task automatic load_use_in();
        idle();
        id_valid = 1; id_rs = 5'd8; id_use_rs = 1; ex_valid = 1; ex_mem_read = 1; ex_dst = 5'd8;
    endtask

    task automatic zero_tallies();
        t_stall = 0; t_flush = 0; t_stall4 = 0; t_flush4 = 0;
        sbq.delete();
    endtask

    task automatic reset_check(input string nm);
        chk({nm, " ctl"}, 32'({stall_if, stall_id, bubble_ex, flush_id, syscall_fire, halted}),
            32'(CtlNone));
        chk({nm, " ctl4"}, 32'({stall_if4, stall_id4, bubble_ex4, flush_id4, syscall_fire4,
            halted4}), 32'(CtlNone));
        chk({nm, " stall_cnt"}, stall_cnt, 32'd0);
        chk({nm, " flush_cnt"}, flush_cnt, 32'd0);
        chk({nm, " stall_cnt4"}, 32'(stall_cnt4), 32'd0);
    endtask

    // Inputs are already driven; queue the expectation, then compare on the falling edge.
    task automatic step(input ctl_t e, input string nm);
        sb_t s;
        s.name = nm; s.ctl = e; s.stall_cnt = t_stall; s.flush_cnt = t_flush;
        s.stall4 = t_stall4; s.flush4 = t_flush4;
        sbq.push_back(s);
        if (e.stall_id) begin
            t_stall++;
            if (t_stall4 != 4'hF) t_stall4++;
        end
        if (e.flush_id) begin
            t_flush++;
            if (t_flush4 != 4'hF) t_flush4++;
        end
        @(negedge clk);
        if (sbq.size() == 0) begin
            chk({nm, " scoreboard empty"}, 32'd0, 32'd1);
        end else begin
            s = sbq.pop_front();
            chk({s.name, " ctl"}, 32'({stall_if, stall_id, bubble_ex, flush_id, syscall_fire,
                halted}), 32'(s.ctl));
            chk({s.name, " ctl4"}, 32'({stall_if4, stall_id4, bubble_ex4, flush_id4,
                syscall_fire4, halted4}), 32'(s.ctl));
            chk({s.name, " stall_cnt"}, stall_cnt, s.stall_cnt);
            chk({s.name, " flush_cnt"}, flush_cnt, s.flush_cnt);
            chk({s.name, " stall_cnt4"}, 32'(stall_cnt4), 32'(s.stall4));
            chk({s.name, " flush_cnt4"}, 32'(flush_cnt4), 32'(s.flush4));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs.push_back(mkv("idle",      0, 0, 0,  0, 0, 0, 0, 0, 0, 0, CtlNone));
        vecs.push_back(mkv("lu_rs",     1, 8, 9,  1, 1, 0, 1, 1, 8, 0, CtlStall));
        vecs.push_back(mkv("lu_zero",   1, 0, 0,  1, 1, 0, 1, 1, 0, 0, CtlNone));
        vecs.push_back(mkv("nonload",   1, 8, 8,  1, 1, 0, 1, 0, 8, 0, CtlNone));
        vecs.push_back(mkv("lu_rt",     1, 3, 8,  1, 1, 0, 1, 1, 8, 0, CtlStall));
        vecs.push_back(mkv("rt_unused", 1, 3, 8,  1, 0, 0, 1, 1, 8, 0, CtlNone));
        vecs.push_back(mkv("id_dead",   0, 8, 8,  1, 1, 0, 1, 1, 8, 0, CtlNone));
        vecs.push_back(mkv("ex_dead",   1, 8, 8,  1, 1, 0, 0, 1, 8, 0, CtlNone));
        vecs.push_back(mkv("redir_lu",  1, 8, 8,  1, 1, 0, 1, 1, 8, 1, CtlFlush));
        vecs.push_back(mkv("redir_sc",  1, 0, 0,  0, 0, 1, 0, 0, 0, 1, CtlFlush));
        vecs.push_back(mkv("lu_sc",     1, 8, 0,  1, 0, 1, 1, 1, 8, 0, CtlStall));
        vecs.push_back(mkv("reg_miss",  1, 9, 10, 1, 1, 0, 1, 1, 8, 0, CtlNone));

        // Reset with hazards present on the inputs: controls must still be low.
        load_use_in();
        id_syscall = 1;
        rst_n = 0;
        zero_tallies();
        #3;
        reset_check("reset");
        idle();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            apply(vecs[i]);
            step(vecs[i].exp, vecs[i].name);
        end

        // Syscall with the pipeline draining one stage per cycle, non-exit service.
        idle(); id_valid = 1; id_syscall = 1; ex_valid = 1; mem_valid = 1; wb_valid = 1;
        step(CtlStall, "sc_run");
        ex_valid = 0;
        step(CtlStall, "sc_drain1");
        mem_valid = 0;
        step(CtlStall, "sc_drain2");
        wb_valid = 0;
        step(CtlStall, "sc_drain3");
        step(CtlFireRun, "sc_fire");
        idle();
        step(CtlNone, "sc_after");
        step(CtlNone, "sc_after2");

        // Exit syscall: halt and stay halted whatever the inputs do.
        idle(); id_valid = 1; id_syscall = 1;
        step(CtlStall, "exit_run");
        step(CtlStall, "exit_drain");
        syscall_halt = 1;
        step(CtlFireHalt, "exit_fire");
        for (int i = 0; i < 100; i++) begin
            id_valid = 1'($urandom_range(0, 1)); id_syscall = 1'($urandom_range(0, 1));
            ex_redirect = 1'($urandom_range(0, 1)); ex_valid = 1'($urandom_range(0, 1));
            syscall_halt = 1'($urandom_range(0, 1));
            step(CtlHalt, "halt_hold");
        end
        #2;
        rst_n = 0;
        #1;
        zero_tallies();
        reset_check("halt_reset");
        idle();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        // Sustained load-use: the 4-bit counters must stick at 15.
        load_use_in();
        for (int i = 0; i < 20; i++) step(CtlStall, "sat_hold");
        @(negedge clk);
        chk("sat stall_cnt4", 32'(stall_cnt4), 32'd15);
        chk("sat stall_cnt", stall_cnt, 32'd20);
        idle();
        @(posedge clk);
        #1;
        t_stall = 20; t_stall4 = 4'd15;
        step(CtlNone, "sat_idle");

        // Reset mid-drain: back to RUN with no fire pulse.
        idle(); id_valid = 1; id_syscall = 1; ex_valid = 1; mem_valid = 1;
        step(CtlStall, "rd_run");
        step(CtlStall, "rd_drain");
        #1;
        rst_n = 0;
        #1;
        zero_tallies();
        reset_check("drain_reset");
        idle();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        ex_redirect = 1;
        step(CtlFlush, "rd_redirect");
        idle();
        for (int i = 0; i < 4; i++) step(CtlNone, "rd_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
